// File: rtl/p_bit_sweep_scheduler.sv
// Sequential (Gibbs) update scheduler for an N-bit p-bit network: one-hot update strobes,
// sweep counting and a one-deep snapshot buffer. Optional annealing via P_BIT_SWEEP_ANNEAL_EN.
module p_bit_sweep_scheduler #(
  parameter int N_BITS          = 5,
  parameter int SHIFT_W         = 2,
  parameter int SETTLE_CYCLES   = 1,
  parameter int SWEEPS_PER_STEP = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [15:0]        num_sweeps,
  input  logic [SHIFT_W-1:0] shift_cfg,
  input  logic [N_BITS-1:0]  state,
  output logic [N_BITS-1:0]  update_en,
  output logic [SHIFT_W-1:0] bit_shift,
  output logic               busy,
  output logic               done,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic [N_BITS-1:0]  sample_data,
  output logic               sample_overrun
);

  localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int SC_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BITS - 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, UPDATE, SETTLE, CAPTURE, DONE} state_t;

  state_t             st;
  logic [IDX_W-1:0]   idx;
  logic [SC_W-1:0]    settle_cnt;
  logic [15:0]        sweep_cnt;
  logic [15:0]        num_sweeps_q;
  logic               start_acc;
  logic               cap_fire;
  logic               buf_free;

  function automatic logic [N_BITS-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot = N_BITS'(1) << i;
  endfunction

  assign start_acc = (st == IDLE) && start;
  // A stop landing on the capture cycle discards that sweep entirely.
  assign cap_fire  = (st == CAPTURE) && !stop;
  assign buf_free  = !sample_valid || sample_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      st           <= IDLE;
      idx          <= '0;
      settle_cnt   <= '0;
      sweep_cnt    <= '0;
      num_sweeps_q <= '0;
      update_en    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      update_en <= '0;
      done      <= 1'b0;
      case (st)
        IDLE: begin
          if (start) begin
            num_sweeps_q <= num_sweeps;
            idx          <= '0;
            sweep_cnt    <= '0;
            busy         <= 1'b1;
            if (num_sweeps == 16'd0) begin
              st   <= DONE;
              done <= 1'b1;
            end else begin
              st        <= UPDATE;
              update_en <= onehot('0);
            end
          end
        end
        UPDATE, SETTLE: begin
          if (stop) begin
            st   <= DONE;
            done <= 1'b1;
          end else if (st == UPDATE && SETTLE_CYCLES != 0) begin
            st         <= SETTLE;
            settle_cnt <= '0;
          end else if (st == SETTLE && settle_cnt != SC_LAST) begin
            settle_cnt <= settle_cnt + 1'b1;
          end else if (idx == IDX_LAST) begin
            st <= CAPTURE;
          end else begin
            idx       <= idx + 1'b1;
            st        <= UPDATE;
            update_en <= onehot(idx + 1'b1);
          end
        end
        CAPTURE: begin
          if (stop) begin
            st   <= DONE;
            done <= 1'b1;
          end else begin
            sweep_cnt <= sweep_cnt + 16'd1;
            // sweep_cnt < num_sweeps_q here, so the 16-bit compare never wraps
            if (sweep_cnt + 16'd1 == num_sweeps_q) begin
              st   <= DONE;
              done <= 1'b1;
            end else begin
              idx       <= '0;
              st        <= UPDATE;
              update_en <= onehot('0);
            end
          end
        end
        DONE: begin
          st   <= IDLE;
          busy <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end

  // One-deep snapshot buffer, decoupled from the sequencer.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_valid   <= 1'b0;
      sample_data    <= '0;
      sample_overrun <= 1'b0;
    end else begin
      if (cap_fire && buf_free) begin
        sample_data  <= state;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
      if (start_acc)
        sample_overrun <= 1'b0;
      else if (cap_fire && !buf_free)
        sample_overrun <= 1'b1;
    end
  end

`ifdef P_BIT_SWEEP_ANNEAL_EN
  localparam int STEP_W = (SWEEPS_PER_STEP > 1) ? $clog2(SWEEPS_PER_STEP) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'((SWEEPS_PER_STEP > 0) ? SWEEPS_PER_STEP - 1 : 0);

  logic [STEP_W-1:0] step_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      step_cnt  <= '0;
      bit_shift <= '0;
    end else if (start_acc) begin
      step_cnt  <= '0;
      bit_shift <= shift_cfg;
    end else if (cap_fire) begin
      if (step_cnt == STEP_LAST) begin
        step_cnt <= '0;
        if (bit_shift != '1)
          bit_shift <= bit_shift + 1'b1;
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset)
      bit_shift <= '0;
    else if (start_acc)
      bit_shift <= shift_cfg;
  end
`endif

endmodule
